spi_reg_ctrl: RTL

Register-file controller behind the `SPISlave` shift register on the board top level. It watches the raw PMOD chip-select and SPI clock to find byte boundaries, and decodes the first byte of each transaction as a command. It then either writes the next byte into a local 8×8 control register bank or presents a register/status byte on the slave's `data_in` for readback. The host microcontroller uses it to configure LEDs and other board logic, and to read switches and status, with a fixed 2-byte protocol.

---
 rtl/spi_reg_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/spi_reg_ctrl.sv
// SPI register-file controller: 2-byte command/data protocol over an 8x8 control bank plus 8 status bytes.
// Define SPI_AUTOINC_EN to allow burst transfers with an auto-incrementing address.
module spi_reg_ctrl #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RESET_VAL   = 8'h00
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        sel_,
  input  logic        sclk,
  input  logic [7:0]  spi_rx,
  output logic [7:0]  spi_tx,
  input  logic [63:0] status_in,
  output logic [63:0] regs_out,
  output logic        wr_stb,
  output logic [2:0]  wr_addr,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DRAIN} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sel_sync_q, sclk_sync_q;
  logic                   sel_prev_q, sclk_prev_q;
  logic [2:0]             cnt_q, cnt_d;
  logic                   byte_done_q, byte_done_d;
  logic                   rw_q, rw_d;
  logic [3:0]             addr_q, addr_d;
  logic [7:0]             spi_tx_q, spi_tx_d;
  logic                   wr_stb_q, wr_stb_d;
  logic [2:0]             wr_addr_q, wr_addr_d;
  logic [7:0]             regs_q [8];
  logic [7:0]             regs_d [8];

  logic       sel_s, sclk_s, sel_fall, sel_rise, sclk_rise;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;

  assign sel_s     = sel_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign sel_fall  = sel_prev_q & ~sel_s;
  assign sel_rise  = ~sel_prev_q & sel_s;
  assign sclk_rise = ~sclk_prev_q & sclk_s;

  // Read source: the incoming command's address at decode, otherwise the next burst address.
  assign rd_addr = (state_q == CMD) ? spi_rx[3:0] : addr_q + 4'd1;
  assign rd_data = rd_addr[3] ? status_in[{rd_addr[2:0], 3'b000} +: 8] : regs_q[rd_addr[2:0]];

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d     = state_q;
    cnt_d       = cnt_q;
    byte_done_d = 1'b0;
    rw_d        = rw_q;
    addr_d      = addr_q;
    spi_tx_d    = spi_tx_q;
    wr_stb_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    regs_d      = regs_q;

    if (sclk_rise && !sel_s) begin
      cnt_d       = cnt_q + 3'd1;
      byte_done_d = (cnt_q == 3'd7);
    end

    case (state_q)
      IDLE: begin
        spi_tx_d = 8'h00;
        if (sel_fall) begin
          cnt_d   = 3'd0;
          state_d = CMD;
        end
      end
      CMD: if (byte_done_q) begin
        rw_d     = spi_rx[7];
        addr_d   = spi_rx[3:0];
        spi_tx_d = spi_rx[7] ? rd_data : 8'h00;
        state_d  = DATA;
      end
      DATA: if (byte_done_q) begin
        if (!rw_q && !addr_q[3]) begin
          regs_d[addr_q[2:0]] = spi_rx;
          wr_stb_d            = 1'b1;
          wr_addr_d           = addr_q[2:0];
        end
`ifdef SPI_AUTOINC_EN
        addr_d   = addr_q + 4'd1;
        spi_tx_d = rw_q ? rd_data : 8'h00;
`else
        spi_tx_d = 8'h00;
        state_d  = DRAIN;
`endif
      end
      DRAIN: spi_tx_d = 8'h00;
      default: state_d = IDLE;
    endcase

    // A byte completing in the same cycle is still committed above before the abort.
    if (state_q != IDLE && sel_rise) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q     <= IDLE;
      sel_sync_q  <= '1;
      sclk_sync_q <= '0;
      sel_prev_q  <= 1'b1;
      sclk_prev_q <= 1'b0;
      cnt_q       <= 3'd0;
      byte_done_q <= 1'b0;
      rw_q        <= 1'b0;
      addr_q      <= 4'd0;
      spi_tx_q    <= 8'h00;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= 3'd0;
      // NOTE: the bank is architectural state with a defined reset value, so it is reset like any flop.
      for (int k = 0; k < 8; k++) regs_q[k] <= RESET_VAL;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values; the sync chain depends on it.
      state_q     <= state_d;
      sel_sync_q  <= {sel_sync_q[SYNC_STAGES-2:0], sel_};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      sel_prev_q  <= sel_s;
      sclk_prev_q <= sclk_s;
      cnt_q       <= cnt_d;
      byte_done_q <= byte_done_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      spi_tx_q    <= spi_tx_d;
      wr_stb_q    <= wr_stb_d;
      wr_addr_q   <= wr_addr_d;
      for (int k = 0; k < 8; k++) regs_q[k] <= regs_d[k];
    end
  end

  always_comb begin
    regs_out = '0;
    for (int k = 0; k < 8; k++) regs_out[8*k +: 8] = regs_q[k];
  end

  assign spi_tx  = spi_tx_q;
  assign wr_stb  = wr_stb_q;
  assign wr_addr = wr_addr_q;
  assign busy    = (state_q != IDLE);

endmodule
